display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 101 ++++++++++
 tb/tb_display_scan.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Multiplexed numeric display scanner: prescaled digit scan with frame-synchronous
// (tear-free) update of the displayed value, sign digit, decimal point and zero blanking.
module display_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int SIGN_EN     = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_DIGITS*4-1:0]       val,
  input  logic                          neg,
  input  logic [$clog2(NUM_DIGITS)-1:0] dp_pos,
  input  logic                          dp_en,
  input  logic                          blank_lz,
  input  logic                          load,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [3:0]                    num,
  output logic                          decimal,
  output logic                          frame_start
);

  localparam int IW  = $clog2(NUM_DIGITS);
  localparam int CW  = $clog2(REFRESH_DIV);
  localparam int MAG = (SIGN_EN != 0) ? NUM_DIGITS - 1 : NUM_DIGITS;

  typedef struct packed {
    logic [NUM_DIGITS*4-1:0] val;
    logic                    neg;
    logic [IW-1:0]           dp_pos;
    logic                    dp_en;
    logic                    blank_lz;
  } disp_t;

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          tick, last, boundary;
  logic          pend_valid, wrap_q;
  disp_t         pend, act, incoming;
  logic [MAG:0]  lead;
  logic [3:0]    digit, code;
  logic          blank, dp_hit;

  assign tick     = (cnt == CW'(REFRESH_DIV - 1));
  assign last     = (idx == IW'(NUM_DIGITS - 1));
  assign boundary = tick && last;
  assign incoming = '{val: val, neg: neg, dp_pos: dp_pos, dp_en: dp_en, blank_lz: blank_lz};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt          <= '0;
      idx          <= '0;
      pend_valid   <= 1'b0;
      pend         <= '0;
      wrap_q       <= 1'b0;
      act.val      <= '0;
      act.neg      <= 1'b0;
      act.dp_pos   <= '0;
      act.dp_en    <= 1'b0;
      act.blank_lz <= 1'b1;
    end else begin
      cnt    <= tick ? '0 : cnt + 1'b1;
      wrap_q <= boundary;
      if (tick) idx <= last ? '0 : idx + 1'b1;
      // The displayed value only moves at a frame boundary; a coincident load wins over pending.
      if (boundary) begin
        pend_valid <= 1'b0;
        if (load)            act <= incoming;
        else if (pend_valid) act <= pend;
      end else if (load) begin
        pend       <= incoming;
        pend_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    lead = '1;
    for (int i = MAG - 1; i >= 0; i--)
      lead[i] = lead[i+1] && (act.val[i*4 +: 4] == 4'd0);
    digit  = act.val[int'(idx)*4 +: 4];
    blank  = act.blank_lz && lead[idx] && (idx != '0) && !(act.dp_en && (idx <= act.dp_pos));
    code   = blank ? 4'd11 : digit;
    if ((SIGN_EN != 0) && last) code = act.neg ? 4'd10 : 4'd11;
    dp_hit = act.dp_en && (idx == act.dp_pos);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an          <= '1;
      num         <= 4'd11;
      decimal     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      an          <= ~(NUM_DIGITS'(1) << idx);
      num         <= code;
      decimal     <= dp_hit;
      frame_start <= wrap_q;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan (4 digits, 4 clocks per slot, sign digit on top).
module tb_display_scan;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] val;
  logic        neg;
  logic [1:0]  dp_pos;
  logic        dp_en;
  logic        blank_lz;
  logic        load;
  logic [3:0]  an;
  logic [3:0]  num;
  logic        decimal;
  logic        frame_start;

  typedef struct {
    logic [3:0] an;
    logic [3:0] num;
    logic       dec;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  display_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SIGN_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .val(val), .neg(neg), .dp_pos(dp_pos),
    .dp_en(dp_en), .blank_lz(blank_lz), .load(load), .an(an), .num(num),
    .decimal(decimal), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Expected digit slot i: an bit i low, frame_start only with digit 0.
  task automatic push_frame(input logic [3:0] d0, d1, d2, d3, input logic [3:0] dpm);
    logic [3:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.an  = ~(4'b0001 << i);
      e.num = d[i];
      e.dec = dpm[i];
      e.fs  = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  // Caller is just after a negedge; returns at the negedge after the capturing posedge.
  task automatic do_load(input logic [15:0] v, input logic n, input logic [1:0] p,
                         input logic de, input logic bz);
    val = v; neg = n; dp_pos = p; dp_en = de; blank_lz = bz; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 40);
    if (frame_start !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s frame_timeout: frame_start=%b after %0d cycles, want 1", tag, frame_start, n);
    end
  endtask

  task automatic read_frame(output logic [3:0][3:0] a, output logic [3:0][3:0] nm,
                            output logic [3:0] d, output logic [3:0] f);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) repeat (4) @(negedge clk);
      a[i] = an; nm[i] = num; d[i] = decimal; f[i] = frame_start;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load = 1'b0; val = '0; neg = 1'b0; dp_pos = '0; dp_en = 1'b0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back('{an: 4'b1111, num: 4'd11, dec: 1'b0, fs: 1'b0});
    begin
      exp_t e = exp_q.pop_front();
      vectors++;
      if ({an, num, decimal, frame_start} !== {e.an, e.num, e.dec, e.fs}) begin
        miscompares++;
        $display("FAIL reset_hold: got an=%b num=%0d dp=%b fs=%b, want an=%b num=%0d dp=%b fs=%b",
                 an, num, decimal, frame_start, e.an, e.num, e.dec, e.fs);
      end
    end
    reset_n = 1'b1;
    // Scan cadence after release: 4 cycles per digit, frame_start 16 cycles after release.
    for (int k = 0; k <= 16; k++) begin
      int s = (k / 4) % 4;
      exp_q.push_back('{an: ~(4'b0001 << s), num: (s == 0) ? 4'd0 : 4'd11, dec: 1'b0, fs: (k == 16)});
    end
    for (int k = 0; k <= 16; k++) begin
      exp_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({an, num, decimal, frame_start} !== {e.an, e.num, e.dec, e.fs}) begin
        miscompares++;
        $display("FAIL scan_step%0d: got an=%b num=%0d dp=%b fs=%b, want an=%b num=%0d dp=%b fs=%b",
                 k, an, num, decimal, frame_start, e.an, e.num, e.dec, e.fs);
      end
    end
  endtask

  task automatic test_load_frame(input string tag, input logic [15:0] v, input logic n,
                                 input logic [1:0] p, input logic de, input logic bz,
                                 input logic [3:0] d0, d1, d2, d3, input logic [3:0] dpm);
    logic [3:0][3:0] a, nm;
    logic [3:0] d, f;
    push_frame(d0, d1, d2, d3, dpm);
    do_load(v, n, p, de, bz);
    wait_frame(tag);
    read_frame(a, nm, d, f);
    for (int i = 0; i < 4; i++) begin
      exp_t e = exp_q.pop_front();
      vectors++;
      if ({a[i], nm[i], d[i], f[i]} !== {e.an, e.num, e.dec, e.fs}) begin
        miscompares++;
        $display("FAIL %s digit%0d: got an=%b num=%0d dp=%b fs=%b, want an=%b num=%0d dp=%b fs=%b",
                 tag, i, a[i], nm[i], d[i], f[i], e.an, e.num, e.dec, e.fs);
      end
    end
  endtask

  // Load while digit 1 is on screen: rest of this frame keeps old data (0123, neg).
  task automatic test_mid_frame_load();
    logic [3:0][3:0] a, nm;
    logic [3:0] d, f;
    exp_q.push_back('{an: 4'b1011, num: 4'd1, dec: 1'b0, fs: 1'b0});
    exp_q.push_back('{an: 4'b0111, num: 4'd10, dec: 1'b0, fs: 1'b0});
    push_frame(4'd6, 4'd5, 4'd4, 4'd11, 4'b0000);
    wait_frame("midload");
    repeat (4) @(negedge clk);
    do_load(16'h0456, 1'b0, 2'd0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (i != 0) repeat (4) @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({an, num, decimal, frame_start} !== {e.an, e.num, e.dec, e.fs}) begin
        miscompares++;
        $display("FAIL midload_old%0d: got an=%b num=%0d dp=%b fs=%b, want an=%b num=%0d dp=%b fs=%b",
                 i + 2, an, num, decimal, frame_start, e.an, e.num, e.dec, e.fs);
      end
    end
    wait_frame("midload_new");
    read_frame(a, nm, d, f);
    for (int i = 0; i < 4; i++) begin
      exp_t e = exp_q.pop_front();
      vectors++;
      if ({a[i], nm[i], d[i], f[i]} !== {e.an, e.num, e.dec, e.fs}) begin
        miscompares++;
        $display("FAIL midload_new digit%0d: got an=%b num=%0d dp=%b fs=%b, want an=%b num=%0d dp=%b fs=%b",
                 i, a[i], nm[i], d[i], f[i], e.an, e.num, e.dec, e.fs);
      end
    end
  endtask

  // Load on the boundary tick itself must appear in the frame that starts right then.
  task automatic test_boundary_load();
    logic [3:0][3:0] a, nm;
    logic [3:0] d, f;
    push_frame(4'd8, 4'd7, 4'd11, 4'd10, 4'b0000);
    wait_frame("bnd_sync");
    repeat (14) @(negedge clk);
    do_load(16'h0078, 1'b1, 2'd0, 1'b0, 1'b1);
    wait_frame("bnd");
    read_frame(a, nm, d, f);
    for (int i = 0; i < 4; i++) begin
      exp_t e = exp_q.pop_front();
      vectors++;
      if ({a[i], nm[i], d[i], f[i]} !== {e.an, e.num, e.dec, e.fs}) begin
        miscompares++;
        $display("FAIL boundary_load digit%0d: got an=%b num=%0d dp=%b fs=%b, want an=%b num=%0d dp=%b fs=%b",
                 i, a[i], nm[i], d[i], f[i], e.an, e.num, e.dec, e.fs);
      end
    end
  endtask

  task automatic test_back_to_back();
    wait_frame("b2b_sync");
    val = 16'h0111; neg = 1'b1; dp_pos = 2'd2; dp_en = 1'b1; blank_lz = 1'b0; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    test_load_frame("back_to_back", 16'h0042, 1'b0, 2'd0, 1'b0, 1'b1,
                    4'd2, 4'd4, 4'd11, 4'd11, 4'b0000);
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0][3:0] a, nm;
    logic [3:0] d, f;
    exp_q.push_back('{an: 4'b1111, num: 4'd11, dec: 1'b0, fs: 1'b0});
    exp_q.push_back('{an: 4'b1110, num: 4'd0, dec: 1'b0, fs: 1'b0});
    push_frame(4'd0, 4'd11, 4'd11, 4'd11, 4'b0000);
    wait_frame("rst_sync");
    do_load(16'h0999, 1'b1, 2'd1, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (i != 0) @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if ({an, num, decimal, frame_start} !== {e.an, e.num, e.dec, e.fs}) begin
        miscompares++;
        $display("FAIL rst_mid%0d: got an=%b num=%0d dp=%b fs=%b, want an=%b num=%0d dp=%b fs=%b",
                 i, an, num, decimal, frame_start, e.an, e.num, e.dec, e.fs);
      end
    end
    wait_frame("rst_after");
    read_frame(a, nm, d, f);
    for (int i = 0; i < 4; i++) begin
      exp_t e = exp_q.pop_front();
      vectors++;
      if ({a[i], nm[i], d[i], f[i]} !== {e.an, e.num, e.dec, e.fs}) begin
        miscompares++;
        $display("FAIL rst_pending_dropped digit%0d: got an=%b num=%0d dp=%b fs=%b, want an=%b num=%0d dp=%b fs=%b",
                 i, a[i], nm[i], d[i], f[i], e.an, e.num, e.dec, e.fs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_frame("sign_dp", 16'h0123, 1'b1, 2'd1, 1'b1, 1'b1, 4'd3, 4'd2, 4'd1, 4'd10, 4'b0010);
    test_mid_frame_load();
    test_load_frame("lz_blank", 16'h0005, 1'b0, 2'd0, 1'b0, 1'b1, 4'd5, 4'd11, 4'd11, 4'd11, 4'b0000);
    test_load_frame("lz_dp", 16'h0005, 1'b0, 2'd1, 1'b1, 1'b1, 4'd5, 4'd0, 4'd11, 4'd11, 4'b0010);
    test_load_frame("nonnum_nz", 16'h0A00, 1'b0, 2'd0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd10, 4'd11, 4'b0000);
    test_load_frame("lz_off", 16'h0007, 1'b0, 2'd3, 1'b1, 1'b0, 4'd7, 4'd0, 4'd0, 4'd11, 4'b1000);
    test_load_frame("top_ignored", 16'h9000, 1'b0, 2'd0, 1'b0, 1'b1, 4'd0, 4'd11, 4'd11, 4'd11, 4'b0000);
    test_boundary_load();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
